// File: rtl/systemx_share_codec_pkg.sv
`default_nettype none
// ============================================================================
// Package    : systemx_mask_pkg
// Description: Shared types and constants for the 2-share SystemX codec:
//              FSM state encoding, share bundle, LFSR taps/unroll depth,
//              mask bit positions and the plaintext reference function.
// Revision   : 1.0 - initial release
// ============================================================================
package systemx_mask_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Boolean share pairs for the three core inputs (x0 ^ x1 == x).
  typedef struct packed {
    logic a0;
    logic a1;
    logic b0;
    logic b1;
    logic c0;
    logic c1;
  } shares_t;

  // Fibonacci feedback taps 32,22,2,1 expressed as bit positions 31,21,1,0.
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam int          LFSR_STEPS = 16;

  // Mask bit positions inside the LFSR state.
  localparam int MASK_A_BIT = 0;
  localparam int MASK_B_BIT = 1;
  localparam int MASK_C_BIT = 2;
  localparam int R_LSB      = 3;
  localparam int R_MSB      = 10;

  // Unmasked function implemented by the core.
  function automatic logic systemx_ref_f(input logic a, input logic b, input logic c);
    return ~c & (~a | b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/systemx_share_codec_if.sv
`default_nettype none
// ============================================================================
// Interface  : systemx_share_codec_if
// Description: Bundles the plaintext input handshake, seed load, the share
//              and refresh-randomness lines to the masked core, the core's
//              output shares and the result handshake.
//              slave  : the codec side
//              master : the environment (producer/consumer/core) side
// Revision   : 1.0 - initial release
// ============================================================================
interface systemx_share_codec_if;
  logic        seed_we;
  logic [31:0] seed_in;
  logic        in_valid;
  logic        in_ready;
  logic        in_a;
  logic        in_b;
  logic        in_c;
  logic        a0;
  logic        a1;
  logic        b0;
  logic        b1;
  logic        c0;
  logic        c1;
  logic [7:0]  r;
  logic        f0;
  logic        f1;
  logic        out_valid;
  logic        out_ready;
  logic        out_f;
  logic        out_err;

  modport slave (
    input  seed_we, seed_in, in_valid, in_a, in_b, in_c, f0, f1, out_ready,
    output in_ready, a0, a1, b0, b1, c0, c1, r, out_valid, out_f, out_err
  );

  modport master (
    output seed_we, seed_in, in_valid, in_a, in_b, in_c, f0, f1, out_ready,
    input  in_ready, a0, a1, b0, b1, c0, c1, r, out_valid, out_f, out_err
  );
endinterface
`default_nettype wire

// File: rtl/systemx_share_codec_lfsr.sv
`default_nettype none
// ============================================================================
// Module     : systemx_lfsr
// Description: 32-bit Fibonacci LFSR (taps 32,22,2,1) advancing LFSR_STEPS
//              steps per clock. A load of zero is replaced by SEED so the
//              register can never lock up in the all-zero state.
// Ports      : clk      - clock
//              rst      - synchronous active-high reset (state <= SEED)
//              load     - load load_val instead of advancing
//              load_val - new state (0 substituted by SEED)
//              state    - current LFSR state
// Revision   : 1.0 - initial release
// ============================================================================
module systemx_lfsr
  import systemx_mask_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_5EED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] state
);

  logic [31:0] state_q;
  logic [31:0] state_d;
  logic [31:0] adv;

  always_comb begin
    adv = state_q;
    // Unrolled multi-step advance: new bit enters at the LSB each step.
    for (int i = 0; i < LFSR_STEPS; i++) begin
      adv = {adv[30:0], ^(adv & LFSR_TAPS)};
    end
    state_d = adv;
    if (load) begin
      state_d = (load_val == 32'd0) ? SEED : load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/systemx_share_codec.sv
`default_nettype none
// ============================================================================
// Module     : systemx_share_codec
// Description: Sequential front/back end for the 2-share masked SystemX core.
//              Accepts plaintext A,B,C, splits each into two Boolean shares
//              using fresh LFSR masks, drives shares and refresh randomness
//              to the core, samples the core's output shares after
//              SETTLE_CYCLES and returns F = ~C & (~A | B).
// Ports      : clk, rst - clock, synchronous active-high reset
//              bus      - systemx_share_codec_if.slave (handshakes, seed,
//                         core shares/randomness, core output shares)
// Options    : SYSTEMX_SHARE_CHECK_EN - when defined, the recombined core
//              output is compared against the function of the held shares
//              and any mismatch sets a sticky out_err. Otherwise out_err=0.
// Revision   : 1.0 - initial release
// ============================================================================
module systemx_share_codec
  import systemx_mask_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [31:0] SEED          = 32'hACE1_5EED
) (
  input logic                  clk,
  input logic                  rst,
  systemx_share_codec_if.slave bus
);

  localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  shares_t          sh_q, sh_d;
  logic [7:0]       r_q, r_d;
  logic             out_f_q, out_f_d;

  logic [31:0]      lfsr_state;
  logic             lfsr_load;
  logic             lfsr_unused;
  logic             sample_en;
  logic             f_unmasked;

  // Seed loads are only honoured while idle; an accept in the same cycle
  // still takes its masks from the current (pre-load) state.
  assign lfsr_load = bus.seed_we && (state_q == IDLE);

  systemx_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (bus.seed_in),
    .state    (lfsr_state)
  );

  // Upper LFSR bits only feed the recurrence, never the masks.
  assign lfsr_unused = ^lfsr_state[31:R_MSB+1];

  assign sample_en  = (state_q == WAIT) && (cnt_q == CNT_W'(1));
  assign f_unmasked = bus.f0 ^ bus.f1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      r_q     <= '0;
      out_f_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      r_q     <= r_d;
      out_f_q <= out_f_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    r_d     = r_q;
    out_f_d = out_f_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Only shares are stored; the plaintext itself never hits a flop.
          sh_d.a0 = lfsr_state[MASK_A_BIT];
          sh_d.a1 = bus.in_a ^ lfsr_state[MASK_A_BIT];
          sh_d.b0 = lfsr_state[MASK_B_BIT];
          sh_d.b1 = bus.in_b ^ lfsr_state[MASK_B_BIT];
          sh_d.c0 = lfsr_state[MASK_C_BIT];
          sh_d.c1 = bus.in_c ^ lfsr_state[MASK_C_BIT];
          r_d     = lfsr_state[R_MSB:R_LSB];
          cnt_d   = CNT_W'(SETTLE_CYCLES);
          state_d = WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (sample_en) begin
          out_f_d = f_unmasked;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          sh_d    = '0;
          r_d     = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SYSTEMX_SHARE_CHECK_EN
  logic err_q;
  logic f_expected;

  assign f_expected = systemx_ref_f(sh_q.a0 ^ sh_q.a1, sh_q.b0 ^ sh_q.b1, sh_q.c0 ^ sh_q.c1);

  // Sticky until reset: any sampled mismatch latches the error.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (sample_en && (f_unmasked != f_expected)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_f     = out_f_q;
  assign bus.a0        = sh_q.a0;
  assign bus.a1        = sh_q.a1;
  assign bus.b0        = sh_q.b0;
  assign bus.b1        = sh_q.b1;
  assign bus.c0        = sh_q.c0;
  assign bus.c1        = sh_q.c1;
  assign bus.r         = r_q;

endmodule
`default_nettype wire

// File: tb/tb_systemx_share_codec.sv
`default_nettype none
// ============================================================================
// Module     : tb_systemx_share_codec
// Description: Scoreboard testbench for systemx_share_codec. Contains a
//              behavioural masked-core model, randomized stimulus, and a
//              monitor that checks results, latency, share integrity,
//              hold stability and idle zeroing. Honours
//              SYSTEMX_SHARE_CHECK_EN for the expected out_err behaviour.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_systemx_share_codec;

  localparam int          SETTLE = 2;
  localparam logic [31:0] SEED   = 32'hACE1_5EED;
`ifdef SYSTEMX_SHARE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic f;
    logic err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   inv_f1 = 1'b0;
  bit   stats_on = 1'b0;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  exp_t exp_q[$];
  bit   wait_valid = 1'b0;
  int   acc_cyc = 0;
  bit   share_pend = 1'b0;
  bit   pa, pb, pc;
  bit   prev_hold = 1'b0;
  logic [15:0] prev_snap = '0;
  bit   err_model = 1'b0;
  int   n_stat = 0, cnt_a = 0, cnt_b = 0, cnt_c = 0;

  systemx_share_codec_if bus ();

  systemx_share_codec #(
    .SETTLE_CYCLES (SETTLE),
    .SEED          (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Masked core model: output shares whose XOR is ~C & (~A | B) of the
  // recombined input shares; f0 is randomized by r and share bits.
  assign bus.f0 = bus.r[0] ^ bus.a0 ^ bus.b1;
  assign bus.f1 = ((~(bus.c0 ^ bus.c1)) & ((~(bus.a0 ^ bus.a1)) | (bus.b0 ^ bus.b1)))
                  ^ bus.f0 ^ inv_f1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [15:0] snap;
    exp_t        e;
    snap = {bus.out_valid, bus.out_f, bus.a0, bus.a1, bus.b0, bus.b1, bus.c0, bus.c1, bus.r};
    if (rst) begin
      exp_q.delete();
      wait_valid = 1'b0;
      share_pend = 1'b0;
      prev_hold  = 1'b0;
      err_model  = 1'b0;
    end else begin
      if (wait_valid) begin
        if (cyc == acc_cyc + 1 + SETTLE) begin
          chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
          wait_valid = 1'b0;
        end else begin
          chk("early_out_valid", 32'(bus.out_valid), 32'd0);
        end
      end
      if (share_pend) begin
        chk("share_a", 32'(bus.a0 ^ bus.a1), 32'(pa));
        chk("share_b", 32'(bus.b0 ^ bus.b1), 32'(pb));
        chk("share_c", 32'(bus.c0 ^ bus.c1), 32'(pc));
        if (stats_on) begin
          n_stat++;
          cnt_a += int'(bus.a0);
          cnt_b += int'(bus.b0);
          cnt_c += int'(bus.c0);
        end
        share_pend = 1'b0;
      end
      if (prev_hold) begin
        chk("hold_stable", 32'(snap), 32'(prev_snap));
      end
      if (bus.out_valid) begin
        chk("valid_has_expect", 32'(exp_q.size()), 32'd1);
        chk("done_in_ready", 32'(bus.in_ready), 32'd0);
        if (bus.out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_f", 32'(bus.out_f), 32'(e.f));
          chk("out_err", 32'(bus.out_err), 32'(e.err));
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_snap = snap;
      if (bus.in_ready) begin
        chk("idle_zero", 32'({bus.a0, bus.a1, bus.b0, bus.b1, bus.c0, bus.c1, bus.r}), 32'd0);
      end
      if (bus.in_valid && bus.in_ready) begin
        pa = bus.in_a;
        pb = bus.in_b;
        pc = bus.in_c;
        e.f = ((!pc) && ((!pa) || pb)) ^ inv_f1;
        if (CHK && inv_f1) err_model = 1'b1;
        e.err = err_model;
        exp_q.push_back(e);
        wait_valid = 1'b1;
        acc_cyc    = cyc;
        share_pend = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit a, input bit b, input bit c, input bit rnd_ready);
    int g;
    bit acc;
    g   = 0;
    acc = 1'b0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_c     = c;
    bus.in_valid = 1'b1;
    while (!acc && g < 200) begin
      acc = bus.in_ready;
      tick();
      g++;
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || !bus.in_ready) && g < 50) begin
      tick();
      g++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] sv;
    int          g;
    bus.seed_we   = 1'b0;
    bus.seed_in   = 32'd0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 1'b0;
    bus.in_b      = 1'b0;
    bus.in_c      = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_f", 32'(bus.out_f), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_shares_r", 32'({bus.a0, bus.a1, bus.b0, bus.b1, bus.c0, bus.c1, bus.r}), 32'd0);
    chk("rst_lfsr", dut.lfsr_state, SEED);
    rst = 1'b0;
    tick();

    // First transaction 0,0,0 then all eight plaintexts
    send(1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      send(v[2], v[1], v[0], 1'b0);
    end
    drain();

    // Zero seed load in IDLE -> SEED; next accept uses SEED's mask bits
    bus.seed_in = 32'd0;
    bus.seed_we = 1'b1;
    tick();
    bus.seed_we = 1'b0;
    chk("seed_zero_lfsr", dut.lfsr_state, SEED);
    send(1'b1, 1'b0, 1'b1, 1'b0);
    sv = SEED;
    chk("seed_mask_a", 32'(bus.a0), 32'(sv[0]));
    chk("seed_mask_b", 32'(bus.b0), 32'(sv[1]));
    chk("seed_mask_c", 32'(bus.c0), 32'(sv[2]));
    chk("seed_r", 32'(bus.r), 32'(sv[10:3]));
    // seed_we outside IDLE must be ignored
    bus.seed_in = 32'h0000_0007;
    bus.seed_we = 1'b1;
    tick();
    bus.seed_we = 1'b0;
    chk("seed_ignored_busy", 32'(dut.lfsr_state == 32'h0000_0007), 32'd0);
    drain();

    // Seed load coinciding with accept: masks from pre-load state (7)
    bus.seed_in = 32'h0000_0007;
    bus.seed_we = 1'b1;
    tick();
    bus.seed_in = 32'd0;
    send(1'b0, 1'b1, 1'b0, 1'b0);
    bus.seed_we = 1'b0;
    chk("coload_lfsr", dut.lfsr_state, SEED);
    chk("coload_masks", 32'({bus.a0, bus.b0, bus.c0}), 32'd7);
    chk("coload_r", 32'(bus.r), 32'd0);
    drain();

    // Randomized traffic with random back-pressure and gaps
    stats_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    stats_on = 1'b0;
    chk("stat_count", 32'(n_stat), 32'd1000);
    chk("mA_40_60", 32'(cnt_a * 100 >= 40 * n_stat && cnt_a * 100 <= 60 * n_stat), 32'd1);
    chk("mB_40_60", 32'(cnt_b * 100 >= 40 * n_stat && cnt_b * 100 <= 60 * n_stat), 32'd1);
    chk("mC_40_60", 32'(cnt_c * 100 >= 40 * n_stat && cnt_c * 100 <= 60 * n_stat), 32'd1);

    // Hold in DONE for 5 cycles with in_valid asserted
    bus.out_ready = 1'b0;
    send(1'b1, 1'b1, 1'b0, 1'b0);
    g = 0;
    while (!bus.out_valid && g < 20) begin
      tick();
      g++;
    end
    chk("hold_reach_done", 32'(bus.out_valid), 32'd1);
    bus.in_a     = 1'b0;
    bus.in_b     = 1'b0;
    bus.in_c     = 1'b1;
    bus.in_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("hold_in_ready_low", 32'(bus.in_ready), 32'd0);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("handoff_idle", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("post_handoff_accept", 32'(bus.in_ready), 32'd0);
    drain();

    // Reset in WAIT cycle 1 discards the result
    send(1'b0, 1'b0, 1'b0, 1'b0);
    pulse_rst();
    chk("rstwait_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rstwait_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstwait_shares", 32'({bus.a0, bus.a1, bus.b0, bus.b1, bus.c0, bus.c1, bus.r}), 32'd0);
    repeat (4) begin
      tick();
      chk("rstwait_no_valid", 32'(bus.out_valid), 32'd0);
    end
    send(1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    // Faulty core: f1 inverted
    inv_f1 = 1'b1;
    send(1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    inv_f1 = 1'b0;
    send(1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    chk("err_sticky", 32'(bus.out_err), 32'(CHK));
    pulse_rst();
    chk("err_cleared", 32'(bus.out_err), 32'd0);
    send(0, 0, 0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
